peripheral_bus_ctrl: RTL

PERIPHERAL_BUS_CTRL -- requirements
Module: peripheral_bus_ctrl

---
 rtl/peripheral_bus_pkg.sv | 9 +
 rtl/bus_wait_counter.sv | 19 +
 rtl/peripheral_bus_ctrl.sv | 132 +++++++++++++
 3 files changed

// File: rtl/peripheral_bus_pkg.sv
// peripheral_bus_pkg: FSM state encoding and default parameters shared by the peripheral bus controller
package peripheral_bus_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DONE} state_t;
  localparam int DEF_NUM_SLOTS = 8;
  localparam int DEF_SLOT_SHIFT = 5;
  localparam int DEF_IO_SPACE_BITS = 10;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_WAIT_WIDTH = 4;
endpackage

// File: rtl/bus_wait_counter.sv
// bus_wait_counter: loadable down-counter for wait states, flags the last wait cycle
// Ports: clock, reset (async, high); i_load/i_value load the count; i_dec decrements; o_terminal high at count 1
module bus_wait_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_load,
  input  logic             i_dec,
  input  logic [WIDTH-1:0] i_value,
  output logic             o_terminal
);
  logic [WIDTH-1:0] r_count;
  always_ff @(posedge clock or posedge reset)
    if (reset) r_count <= '0;
    else if (i_load) r_count <= i_value;
    else if (i_dec && r_count != '0) r_count <= r_count - 1'b1;
  assign o_terminal = r_count == WIDTH'(1);
endmodule

// File: rtl/peripheral_bus_ctrl.sv
// peripheral_bus_ctrl: I/O slot decoder with wait states, read-data latch and optional unmapped-access trap (macro IO_TRAP_EN)
// Ports: clock, reset (async, high); address_enable_n/io_read_n/io_write_n/address: bus cycle;
//   slot_enable/slot_wait/slot_data_in: per-slot config and read data; slot_chip_select_n: active-low selects;
//   data_bus_out/data_bus_out_from_chipset: latched read data and its drive enable; io_ready: low inserts waits;
//   trap_valid/trap_address/trap_clear: sticky record of the last access to a disabled slot
module peripheral_bus_ctrl
  import peripheral_bus_pkg::*;
#(
  parameter int NUM_SLOTS     = DEF_NUM_SLOTS,
  parameter int SLOT_SHIFT    = DEF_SLOT_SHIFT,
  parameter int IO_SPACE_BITS = DEF_IO_SPACE_BITS,
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int WAIT_WIDTH    = DEF_WAIT_WIDTH
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            address_enable_n,
  input  logic                            io_read_n,
  input  logic                            io_write_n,
  input  logic [19:0]                     address,
  input  logic [NUM_SLOTS-1:0]            slot_enable,
  input  logic [NUM_SLOTS*WAIT_WIDTH-1:0] slot_wait,
  input  logic [NUM_SLOTS*DATA_WIDTH-1:0] slot_data_in,
  output logic [NUM_SLOTS-1:0]            slot_chip_select_n,
  output logic [DATA_WIDTH-1:0]           data_bus_out,
  output logic                            data_bus_out_from_chipset,
  output logic                            io_ready,
  output logic                            trap_valid,
  output logic [IO_SPACE_BITS-1:0]        trap_address,
  input  logic                            trap_clear
);
  localparam int SLOT_BITS = $clog2(NUM_SLOTS);
  state_t r_state, w_next;
  logic [SLOT_BITS-1:0] r_index, w_index, w_cur_index;
  logic [WAIT_WIDTH-1:0] w_wait;
  logic [DATA_WIDTH-1:0] r_data, w_sel_data;
  logic r_read, r_mapped;
  logic w_idle, w_strobe, w_access, w_mapped, w_cs_on, w_load, w_dec, w_terminal, w_capture;
  assign w_idle = r_state == ST_IDLE;
  assign w_strobe = ~address_enable_n & (~io_read_n | ~io_write_n);
  assign w_access = w_strobe & ((address[IO_SPACE_BITS-1:0] >> (SLOT_SHIFT + SLOT_BITS)) == '0);
  assign w_index = address[SLOT_SHIFT +: SLOT_BITS];
  assign w_mapped = w_access & slot_enable[w_index];
  assign w_wait = slot_wait[w_index*WAIT_WIDTH +: WAIT_WIDTH];
  // Once an access has started the decode is frozen, so later address changes cannot move the select
  assign w_cur_index = w_idle ? w_index : r_index;
  assign w_cs_on = w_idle ? w_mapped : r_mapped & w_strobe;
  assign w_sel_data = slot_data_in[w_cur_index*DATA_WIDTH +: DATA_WIDTH];
  assign slot_chip_select_n = w_cs_on ? ~(NUM_SLOTS'(1) << w_cur_index) : '1;
  assign data_bus_out = r_data;
  assign data_bus_out_from_chipset = (r_state == ST_DONE) & r_mapped & r_read & ~io_read_n;
  bus_wait_counter #(.WIDTH(WAIT_WIDTH)) u_wait (
    .clock      (clock),
    .reset      (reset),
    .i_load     (w_load),
    .i_dec      (w_dec),
    .i_value    (w_wait),
    .o_terminal (w_terminal)
  );
  always_ff @(posedge clock or posedge reset)
    if (reset) r_state <= ST_IDLE;
    else r_state <= w_next;
  // Ready is low for the start cycle plus the first N-1 wait cycles; it rises in the final
  // wait cycle so the host sees exactly N low cycles before data is latched into DONE.
  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    w_dec = 1'b0;
    w_capture = 1'b0;
    io_ready = 1'b1;
    unique case (r_state)
      ST_IDLE:
        if (w_access) begin
          if (w_mapped && w_wait != '0) begin
            w_next = ST_WAIT;
            w_load = 1'b1;
            io_ready = 1'b0;
          end else begin
            w_next = ST_DONE;
            w_capture = w_mapped & ~io_read_n;
          end
        end
      ST_WAIT:
        if (!w_strobe) w_next = ST_IDLE;
        else begin
          w_dec = 1'b1;
          io_ready = w_terminal;
          w_next = w_terminal ? ST_DONE : ST_WAIT;
          w_capture = w_terminal & r_read;
        end
      ST_DONE: w_next = w_strobe ? ST_DONE : ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      r_index <= '0;
      r_read <= 1'b0;
      r_mapped <= 1'b0;
      r_data <= '0;
    end else begin
      if (w_idle && w_access) begin
        r_index <= w_index;
        r_read <= ~io_read_n;
        r_mapped <= w_mapped;
      end
      if (w_capture) r_data <= w_sel_data;
    end
  logic w_unused_addr;
  assign w_unused_addr = ^address[19:IO_SPACE_BITS];
`ifdef IO_TRAP_EN
  logic r_trap_valid, w_trap;
  logic [IO_SPACE_BITS-1:0] r_trap_address;
  assign w_trap = w_idle & w_access & ~w_mapped;
  // A trap in the same cycle as trap_clear must survive, so it takes priority
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      r_trap_valid <= 1'b0;
      r_trap_address <= '0;
    end else if (w_trap) begin
      r_trap_valid <= 1'b1;
      r_trap_address <= address[IO_SPACE_BITS-1:0];
    end else if (trap_clear) r_trap_valid <= 1'b0;
  assign trap_valid = r_trap_valid;
  assign trap_address = r_trap_address;
`else
  logic w_unused_trap_clear;
  assign w_unused_trap_clear = trap_clear;
  assign trap_valid = 1'b0;
  assign trap_address = '0;
`endif
endmodule
